// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared state encoding, constants and helpers for the
// sequential restoring divider (seq_divider) and its step slice (div_step).
package seq_divider_pkg;

  // Controller states. The encoding is fixed so that external checkers can
  // decode the state register directly.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit replicated WIDTH times to form the unsigned divide-by-zero quotient
  // (all ones, i.e. the largest representable value).
  localparam logic DBZ_Q_BIT = 1'b1;

  // Width of a counter that must hold the values 0..width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational restoring-division step.
// Shifts the next dividend bit into the partial remainder, makes a trial
// subtraction of the divisor, and keeps the difference only when it is
// non-negative. The quotient bit is 1 exactly when the difference is kept.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   p_i,        // partial remainder, MSB is 0 between steps
  input  logic             bit_i,      // next dividend bit (MSB first)
  input  logic [WIDTH-1:0] divisor_i,  // non-zero divisor magnitude
  output logic [WIDTH:0]   p_o,        // updated partial remainder
  output logic             q_o         // quotient bit produced by this step
);

  // The trial difference is one bit wider than the shifted remainder so its
  // top bit is a reliable sign: the shifted value is below 2^(WIDTH+1) and the
  // divisor below 2^WIDTH, so the true difference always fits.
  logic [WIDTH+1:0] trial;

  // Trial subtraction and restore/keep selection.
  always_comb begin
    trial = {p_i, bit_i} - {2'b00, divisor_i};
    q_o   = ~trial[WIDTH+1];
    p_o   = q_o ? trial[WIDTH:0] : {p_i[WIDTH-1:0], bit_i};
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring radix-2 integer divider.
// One quotient bit per clock; done pulses WIDTH+1 cycles after a start with a
// non-zero divisor, or one cycle after a start with a zero divisor.
//
// Handshake: start is accepted only on a rising edge where the controller is
// in IDLE (busy=0 and done=0); starts seen at any other time are dropped, not
// queued. dividend/divisor are sampled on that accept edge. done is a single
// cycle pulse; quotient, remainder and div_by_zero are valid from the done
// cycle and held until the done of the next accepted operation (div_by_zero
// alone is cleared on the next accept).
//
// Build option: define SEQ_DIVIDER_SIGNED_EN for two's-complement operands
// (truncating division, remainder follows the dividend sign). Without it the
// divider is unsigned only and no sign logic exists.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // Controller state; this register is the probe point for state checkers.
  state_e           state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;      // steps still to perform
  logic [WIDTH:0]   p_q, p_d;          // partial remainder
  logic [WIDTH-1:0] sh_q, sh_d;        // dividend bits out at MSB, quotient bits in at LSB
  logic [WIDTH-1:0] dvs_q, dvs_d;      // latched divisor magnitude
  logic [WIDTH-1:0] quo_q, quo_d;      // held quotient result
  logic [WIDTH-1:0] rem_q, rem_d;      // held remainder result
  logic             dbz_q, dbz_d;      // held divide-by-zero flag

  logic [WIDTH:0]   step_p;            // remainder after this cycle's step
  logic             step_bit;          // quotient bit from this cycle's step
  logic [WIDTH-1:0] op_a;              // dividend as fed to the unsigned core
  logic [WIDTH-1:0] op_b;              // divisor as fed to the unsigned core
  logic [WIDTH-1:0] dbz_quo;           // quotient reported for a zero divisor
  logic [WIDTH-1:0] fin_quo;           // unsigned quotient after the last step
  logic [WIDTH-1:0] fin_rem;           // unsigned remainder after the last step
  logic [WIDTH-1:0] res_quo;           // final quotient after sign fix-up
  logic [WIDTH-1:0] res_rem;           // final remainder after sign fix-up

  // The last step's outputs are taken straight from the step slice so the
  // results land in the same edge that enters DONE.
  assign fin_quo = {sh_q[WIDTH-2:0], step_bit};
  assign fin_rem = step_p[WIDTH-1:0];

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic qneg_q, qneg_d;                // quotient must be negated
  logic rneg_q, rneg_d;                // remainder must be negated (dividend < 0)

  // Magnitudes go through the unsigned core. The most negative value maps to
  // itself, which read as unsigned is exactly its magnitude, so MIN / -1
  // naturally yields MIN with a zero remainder.
  assign op_a    = dividend[WIDTH-1] ? -dividend : dividend;
  assign op_b    = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign dbz_quo = dividend[WIDTH-1] ? WIDTH'(1) : {WIDTH{DBZ_Q_BIT}};
  assign res_quo = qneg_q ? -fin_quo : fin_quo;
  assign res_rem = rneg_q ? -fin_rem : fin_rem;
`else
  assign op_a    = dividend;
  assign op_b    = divisor;
  assign dbz_quo = {WIDTH{DBZ_Q_BIT}};
  assign res_quo = fin_quo;
  assign res_rem = fin_rem;
`endif

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .p_i      (p_q),
    .bit_i    (sh_q[WIDTH-1]),
    .divisor_i(dvs_q),
    .p_o      (step_p),
    .q_o      (step_bit)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    sh_d    = sh_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            // No iteration needed: report the fixed pattern next cycle.
            state_d = ST_DONE;
            quo_d   = dbz_quo;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_RUN;
            cnt_d   = CNT_W'(WIDTH);
            p_d     = '0;
            sh_d    = op_a;
            dvs_d   = op_b;
            dbz_d   = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rneg_d  = dividend[WIDTH-1];
`endif
          end
        end
      end
      ST_RUN: begin
        p_d   = step_p;
        sh_d  = fin_quo;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Final step: register the (sign-corrected) results on DONE entry.
          state_d = ST_DONE;
          quo_d   = res_quo;
          rem_d   = res_rem;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and result registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      p_q    <= '0;
      sh_q   <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      p_q    <= p_d;
      sh_q   <= sh_d;
      dvs_q  <= dvs_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
`endif
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomised checks of seq_divider (WIDTH=8).
// Latency is counted in cycles after the accept edge: cycle 1 is the cycle
// that follows the accept edge. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_seq_divider;

  localparam int W         = 8;
  localparam int LAT_LIMIT = 40;
  localparam int N_RAND    = 1000;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int           err_cnt = 0;
  int           chk_cnt = 0;
  logic [W-1:0] exp_q[$];

  seq_divider #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
`ifdef SEQ_DIVIDER_SIGNED_EN
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    z  = 1'b0;
    if (sb == 0) begin
      q = (sa >= 0) ? 8'hFF : 8'h01;
      r = a;
      z = 1'b1;
    end else if (sa == -128 && sb == -1) begin
      q = 8'h80;
      r = 8'h00;
    end else begin
      q = 8'(sa / sb);
      r = 8'(sa % sb);
    end
`else
    z = 1'b0;
    if (b == 0) begin
      q = 8'hFF;
      r = a;
      z = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
    end
`endif
  endfunction

  // ---------------- drivers ----------------
  // Present operands with start for one edge; returns at cycle 1.
  task automatic drive_accept(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic push_expected(input logic [W-1:0] q, input logic [W-1:0] r);
    exp_q.push_back(q);
    exp_q.push_back(r);
  endtask

  // Wait (bounded) for done, counting cycles from lat0.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (done !== 1'b1 && lat < LAT_LIMIT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Wait for done, compare against the scoreboard, then confirm the pulse
  // ends and the results are held.
  task automatic finish_div(input string tag, input logic exp_dbz, input int exp_lat, input int lat0);
    int lat;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    wait_done(lat0, lat);
    eq = exp_q.pop_front();
    er = exp_q.pop_front();
    check_eq({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    check_eq({tag, ".quotient"}, 32'(quotient), 32'(eq));
    check_eq({tag, ".remainder"}, 32'(remainder), 32'(er));
    check_eq({tag, ".div_by_zero"}, 32'(div_by_zero), 32'(exp_dbz));
    @(negedge clk);
    check_eq({tag, ".done_pulse"}, 32'(done), 32'd0);
    check_eq({tag, ".quotient_hold"}, 32'(quotient), 32'(eq));
  endtask

  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r, input logic z, input int lat);
    push_expected(q, r);
    drive_accept(a, b);
    finish_div(tag, z, lat, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] rq;
    logic [W-1:0] rr;
    logic         rz;
    logic         saw_done;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);

    check_eq("reset.busy", 32'(busy), 32'd0);
    check_eq("reset.done", 32'(done), 32'd0);
    check_eq("reset.quotient", 32'(quotient), 32'd0);
    check_eq("reset.remainder", 32'(remainder), 32'd0);
    check_eq("reset.div_by_zero", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_div("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, W + 1);
    run_div("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, W + 1);
    run_div("d5_200", 8'd5, 8'd200, 8'd0, 8'd5, 1'b0, W + 1);
    run_div("d37_0", 8'd37, 8'd0, 8'hFF, 8'd37, 1'b1, 1);

    // New accept clears the flag at once but results hold until done.
    push_expected(8'd7, 8'd2);
    drive_accept(8'd37, 8'd5);
    check_eq("d37_5.flag_cleared", 32'(div_by_zero), 32'd0);
    check_eq("d37_5.old_quotient", 32'(quotient), 32'hFF);
    check_eq("d37_5.old_remainder", 32'(remainder), 32'd37);
    finish_div("d37_5", 1'b0, W + 1, 1);

    // start pulsed mid-RUN with other operands must be ignored.
    push_expected(8'd13, 8'd3);
    drive_accept(8'd120, 8'd9);
    for (int c = 1; c <= W; c++) begin
      check_eq("midrun.busy", 32'(busy), 32'd1);
      if (c == 3) begin
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
      end else begin
        start    = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    finish_div("midrun", 1'b0, W + 1, W + 1);
    check_eq("midrun.not_queued", 32'(busy), 32'd0);

    // Asynchronous reset between edges during RUN.
    drive_accept(8'd100, 8'd7);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("arst.busy", 32'(busy), 32'd0);
    check_eq("arst.quotient", 32'(quotient), 32'd0);
    check_eq("arst.remainder", 32'(remainder), 32'd0);
    // start held during reset over a clock edge: reset wins.
    start    = 1'b1;
    dividend = 8'd9;
    divisor  = 8'd3;
    @(negedge clk);
    check_eq("arst.start_ignored", 32'(busy), 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    check_eq("arst.no_done", 32'(saw_done), 32'd0);
    run_div("d9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, W + 1);

`ifdef SEQ_DIVIDER_SIGNED_EN
    run_div("s_m100_7", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, W + 1);
    run_div("s_m128_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, W + 1);
    run_div("s_m37_0", 8'hDB, 8'd0, 8'h01, 8'hDB, 1'b1, 1);
`endif

    for (int i = 0; i < N_RAND; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      model(ra, rb, rq, rr, rz);
      run_div("random", ra, rb, rq, rr, rz, (rb == 0) ? 1 : W + 1);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised multi-cycle integer divider: computes quotient and remainder of DIVIDEND / DIVISOR over WIDTH bits.
- Uses restoring radix-2 division, one quotient bit per clock.
- Start/done handshake; operands latched on accept, results held until the next accepted start.
- Serves as the datapath arithmetic unit alongside the team's adder and comparator blocks. Replaces the repeated-subtraction divider, whose latency was data-dependent.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH+1), width of the internal step counter (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- dividend  input  WIDTH  numerator, sampled on the accept edge.
- divisor  input  WIDTH  denominator, sampled on the accept edge.
- busy  output  1  high from the cycle after accept until done.
- done  output  1  one-cycle pulse; quotient/remainder valid from this cycle on.
- quotient  output  WIDTH  result, held until the next accept.
- remainder  output  WIDTH  result, held until the next accept.
- div_by_zero  output  1  set with done when divisor==0; held like the results.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; counter=0. Any in-flight operation is abandoned with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE to RUN: on start=1 with divisor!=0.
  - Latch the dividend into the shift register and the divisor into a register.
  - Clear the partial remainder (WIDTH+1 bits) and load counter=WIDTH.
- IDLE to DONE: on start=1 with divisor==0. Next cycle: quotient=all-ones, remainder=dividend, div_by_zero=1, done=1. Latency is 1 cycle.
- RUN, each cycle:
  - Form P' = {P[WIDTH-1:0], msb of the shift register}, then compute T = P' - {0,divisor}.
  - If T is non-negative: P=T and shift quotient bit 1 into the LSB. Otherwise P=P' and shift in 0.
  - Decrement the counter. When the counter reaches 1 in RUN, the next state is DONE.
- DONE: done=1 for exactly one cycle; quotient and remainder registered; next state IDLE; busy=0 in this cycle.
- Latency: done asserts exactly WIDTH+1 cycles after the accept edge for divisor!=0, independent of data.
- start while busy=1 or during DONE: ignored, no queueing. start in the same cycle as reset: reset wins.
- A new accept clears div_by_zero. Results keep their old values until the new done.
- Arithmetic: unsigned. Invariant: dividend = quotient*divisor + remainder, with remainder < divisor.
- Remainder register width is WIDTH+1 internally; the output is truncated to WIDTH (MSB is always 0 at completion).

Optional Feature:
- Macro SEQ_DIVIDER_SIGNED_EN.
- Defined:
  - Operands are two's complement. The magnitudes are divided by the same unsigned core.
  - Quotient is negated if the operand signs differ (truncation toward zero).
  - Remainder takes the sign of the dividend.
  - Signed overflow (MIN / -1) gives quotient=MIN, remainder=0, no flag.
  - Divide-by-zero gives quotient=-1 if the dividend is >=0, else +1; remainder=dividend.
  - Latency unchanged: sign fix-up is applied in the DONE-entry cycle.
- Undefined: unsigned only; no sign logic is synthesised.

Decomposition:
- Package seq_divider_pkg:
  - State enum (IDLE/RUN/DONE, 2-bit encoding).
  - Localparam for the divide-by-zero quotient pattern.
  - Function for counter width.
- Sub-module div_step: combinational single restoring step (inputs P, next dividend bit, divisor; outputs new P, quotient bit). Instantiated once in the RUN datapath.

Test Plan:
- WIDTH=8, 100/7 → done at exactly 9 cycles after accept; quotient=14, remainder=2, div_by_zero=0.
- 255/1 and 5/200 → quotient=255, remainder=0; then quotient=0, remainder=5.
- 37/0 → done 1 cycle after accept; quotient=8'hFF, remainder=37, div_by_zero=1; next 37/5 accept clears the flag, giving 7 r 2.
- start pulsed mid-RUN with other operands → ignored; original result returned; busy stays high through RUN.
- rst asserted asynchronously mid-RUN (between edges) → outputs 0 immediately, no done pulse; subsequent 9/3 → quotient 3, remainder 0.
- SEQ_DIVIDER_SIGNED_EN: -100/7 → quotient -14, remainder -2; -128/-1 → quotient -128, remainder 0; random 1000-vector check against the reference model in both builds.
